network_rx_arbiter: RTL and testbench

NETWORK_RX_ARBITER -- requirements
Module: network_rx_arbiter

---
 rtl/network_rx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_network_rx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_rx_arbiter.sv
// Packet-granular round-robin merge of four show-ahead RX FIFOs into one stream.
// Define NETWORK_RX_ARB_WATCHDOG_EN to force a tail after WATCHDOG_CYCLES empty cycles mid-packet.
module network_rx_arbiter #(
    parameter logic [7:0] WATCHDOG_CYCLES = 8'd255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [35:0] iv_data,
    input  logic [3:0]  iv_data_empty,
    output logic [3:0]  ov_data_rd,
    input  logic [18:0] timer,
    input  logic        i_out_ready,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic [1:0]  ov_port_id,
    output logic [18:0] ov_rec_ts,
    output logic        o_pkt_valid_pulse,
    output logic        o_head_error_pulse,
    output logic        o_fifo_underflow_pulse,
    output logic [1:0]  report_arb_state
);
    // state   | meaning
    // IDLE    | wait for ready and a non-empty port, then grant round-robin
    // HEAD    | pop the granted port's first word and validate it
    // TRAN    | forward body words until the tail word
    // DISCARD | drain a malformed or timed-out packet through its tail

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_TRAN    = 2'd2,
        ST_DISCARD = 2'd3
    } arb_state_t;

    arb_state_t state, state_nxt;
    logic [1:0]  grant, grant_nxt;
    logic [1:0]  last_grant, last_grant_nxt;
    logic [8:0]  port_word [4];
    logic [8:0]  cur_word;
    logic        cur_empty;
    logic        arb_found;
    logic [1:0]  arb_port;
    logic        wd_timeout;

    logic [8:0]  data_nxt;
    logic        wr_nxt;
    logic [1:0]  port_id_nxt;
    logic [18:0] ts_nxt;
    logic        pkt_valid_nxt;
    logic        head_err_nxt;
    logic        underflow_nxt;

    for (genvar p = 0; p < 4; p++) begin : g_port
        assign port_word[p] = iv_data[9*p +: 9];
    end

    assign cur_word  = port_word[grant];
    assign cur_empty = iv_data_empty[grant];

    always_comb begin
        arb_found = 1'b0;
        arb_port  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (!arb_found && !iv_data_empty[last_grant + 2'(i)]) begin
                arb_found = 1'b1;
                arb_port  = last_grant + 2'(i);
            end
        end
    end

`ifdef NETWORK_RX_ARB_WATCHDOG_EN
    logic [7:0] empty_cnt;

    // Fires on the WATCHDOG_CYCLES-th consecutive empty cycle inside a packet.
    assign wd_timeout = (state == ST_TRAN) && cur_empty &&
                        (empty_cnt == WATCHDOG_CYCLES - 8'd1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            empty_cnt <= 8'd0;
        else if ((state == ST_TRAN) && cur_empty && !wd_timeout)
            empty_cnt <= empty_cnt + 8'd1;
        else
            empty_cnt <= 8'd0;
    end
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= ST_IDLE;
            grant                  <= 2'd0;
            last_grant             <= 2'd3;
            ov_data                <= 9'h000;
            o_data_wr              <= 1'b0;
            ov_port_id             <= 2'd0;
            ov_rec_ts              <= 19'd0;
            o_pkt_valid_pulse      <= 1'b0;
            o_head_error_pulse     <= 1'b0;
            o_fifo_underflow_pulse <= 1'b0;
        end else begin
            state                  <= state_nxt;
            grant                  <= grant_nxt;
            last_grant             <= last_grant_nxt;
            ov_data                <= data_nxt;
            o_data_wr              <= wr_nxt;
            ov_port_id             <= port_id_nxt;
            ov_rec_ts              <= ts_nxt;
            o_pkt_valid_pulse      <= pkt_valid_nxt;
            o_head_error_pulse     <= head_err_nxt;
            o_fifo_underflow_pulse <= underflow_nxt;
        end
    end

    assign report_arb_state = state;

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (i_out_ready && arb_found) begin
                    grant_nxt = arb_port;
                    state_nxt = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (!cur_empty)
                    state_nxt = cur_word[8] ? ST_TRAN : ST_DISCARD;
            end
            ST_TRAN: begin
                if (!cur_empty) begin
                    if (cur_word[8]) begin
                        last_grant_nxt = grant;
                        state_nxt      = ST_IDLE;
                    end
                end else if (wd_timeout) begin
                    state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (!cur_empty && cur_word[8]) begin
                    last_grant_nxt = grant;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ov_data_rd    = 4'b0000;
        data_nxt      = 9'h000;
        wr_nxt        = 1'b0;
        port_id_nxt   = ov_port_id;
        ts_nxt        = 19'd0;
        pkt_valid_nxt = 1'b0;
        head_err_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        case (state)
            ST_HEAD: begin
                if (!cur_empty) begin
                    ov_data_rd = 4'b0001 << grant;
                    if (cur_word[8]) begin
                        data_nxt    = cur_word;
                        wr_nxt      = 1'b1;
                        ts_nxt      = timer;
                        port_id_nxt = grant;
                    end else begin
                        head_err_nxt = 1'b1;
                    end
                end
            end
            ST_TRAN: begin
                if (!cur_empty) begin
                    ov_data_rd    = 4'b0001 << grant;
                    data_nxt      = cur_word;
                    wr_nxt        = 1'b1;
                    pkt_valid_nxt = cur_word[8];
                end else if (wd_timeout) begin
                    data_nxt      = 9'h100;
                    wr_nxt        = 1'b1;
                    underflow_nxt = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (!cur_empty)
                    ov_data_rd = 4'b0001 << grant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_network_rx_arbiter.sv
// Bench for network_rx_arbiter: queue-backed show-ahead FIFOs feed the DUT and a
// packet-level round-robin model predicts the merged output stream.
module tb_network_rx_arbiter;
    logic        clk_sys;
    logic        reset_n;
    logic [35:0] iv_data;
    logic [3:0]  iv_data_empty;
    logic [3:0]  ov_data_rd;
    logic [18:0] timer;
    logic        i_out_ready;
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic [1:0]  ov_port_id;
    logic [18:0] ov_rec_ts;
    logic        o_pkt_valid_pulse;
    logic        o_head_error_pulse;
    logic        o_fifo_underflow_pulse;
    logic [1:0]  report_arb_state;

    network_rx_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .iv_data(iv_data),
        .iv_data_empty(iv_data_empty), .ov_data_rd(ov_data_rd), .timer(timer),
        .i_out_ready(i_out_ready), .ov_data(ov_data), .o_data_wr(o_data_wr),
        .ov_port_id(ov_port_id), .ov_rec_ts(ov_rec_ts),
        .o_pkt_valid_pulse(o_pkt_valid_pulse), .o_head_error_pulse(o_head_error_pulse),
        .o_fifo_underflow_pulse(o_fifo_underflow_pulse), .report_arb_state(report_arb_state)
    );

    typedef logic [8:0] wq_t[$];
    typedef struct {
        logic [8:0] word;
        logic [1:0] port;
        bit         head;
        bit         forced;
    } exp_t;

    wq_t   fifo [4];
    wq_t   mdl  [4];
    exp_t  exp_q[$];
    int    head_log[$];
    int    wr_cyc[$];
    int    checks = 0, errors = 0;
    int    lg_m = 3;
    int    he_exp = 0, he_seen = 0, uf_seen = 0, pv_seen = 0, writes = 0;
    int    bad_pops = 0, cyc = 0;
    logic [18:0] ts_seen = '0;
    logic [3:0]  rd_lat;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic int fifo_total();
        int t = 0;
        for (int p = 0; p < 4; p++) t += fifo[p].size();
        return t;
    endfunction

    function automatic int hl(input int i);
        return (i < head_log.size()) ? head_log[i] : 7;
    endfunction

    // FIFO driver: pops on the strobe seen this cycle, then presents the new heads.
    initial begin
        forever begin
            @(negedge clk_sys);
            rd_lat = ov_data_rd;
            if ($countones(rd_lat) > 1) bad_pops++;
            @(posedge clk_sys);
            ts_seen = timer;
            #1;
            for (int p = 0; p < 4; p++) begin
                if (rd_lat[p]) begin
                    if (fifo[p].size() == 0) bad_pops++;
                    else void'(fifo[p].pop_front());
                end
            end
            timer = timer + 19'd1;
            for (int p = 0; p < 4; p++) begin
                iv_data_empty[p]  = (fifo[p].size() == 0);
                iv_data[9*p +: 9] = (fifo[p].size() == 0) ? 9'h000 : fifo[p][0];
            end
        end
    end

    // Compare process: every cycle out of reset, the outputs are checked against the model stream.
    initial begin
        bit in_pkt;
        exp_t e;
        in_pkt = 1'b0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (!reset_n) begin
                in_pkt = 1'b0;
                continue;
            end
            if (o_head_error_pulse) he_seen++;
            if (o_fifo_underflow_pulse) uf_seen++;
            if (o_pkt_valid_pulse) pv_seen++;
            if (o_data_wr) begin
                writes++;
                wr_cyc.push_back(cyc);
                if (ov_data[8]) begin
                    if (!in_pkt) begin
                        head_log.push_back(int'(ov_port_id));
                        in_pkt = 1'b1;
                    end else begin
                        in_pkt = 1'b0;
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data %0h expected no write", ov_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(ov_data), 32'(e.word));
                    chk("port_id", 32'(ov_port_id), 32'(e.port));
                    chk("rec_ts", 32'(ov_rec_ts), e.head ? 32'(ts_seen) : 32'd0);
                    chk("pkt_valid", 32'(o_pkt_valid_pulse), 32'(e.word[8] && !e.head && !e.forced));
                    chk("underflow", 32'(o_fifo_underflow_pulse), 32'(e.forced));
                end
            end else begin
                chk("idle_data", 32'(ov_data), 32'd0);
                chk("idle_ts", 32'(ov_rec_ts), 32'd0);
                chk("idle_pkt_valid", 32'(o_pkt_valid_pulse), 32'd0);
                chk("idle_underflow", 32'(o_fifo_underflow_pulse), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push_word(input int p, input logic [8:0] w);
        fifo[p].push_back(w);
        mdl[p].push_back(w);
    endtask

    task automatic load_pkt(input int p, input int n, input int seed);
        for (int i = 0; i < n; i++)
            push_word(p, {(i == 0 || i == n - 1), 8'(seed + 7 * i + 64 * p)});
    endtask

    // Packet-level model: round-robin over ports holding words, headless packets discarded.
    task automatic predict();
        int p;
        bit found;
        logic [8:0] w;
        forever begin
            found = 1'b0;
            p = 0;
            for (int i = 1; i <= 4; i++) begin
                if (!found && mdl[(lg_m + i) % 4].size() != 0) begin
                    found = 1'b1;
                    p = (lg_m + i) % 4;
                end
            end
            if (!found) break;
            w = mdl[p].pop_front();
            if (!w[8]) begin
                he_exp++;
                while (!w[8] && mdl[p].size() != 0) w = mdl[p].pop_front();
            end else begin
                exp_q.push_back('{w, 2'(p), 1'b1, 1'b0});
                do begin
                    w = mdl[p].pop_front();
                    exp_q.push_back('{w, 2'(p), 1'b0, 1'b0});
                end while (!w[8] && mdl[p].size() != 0);
            end
            lg_m = p;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        i_out_ready = 1'b0;
        tick(2);
        for (int p = 0; p < 4; p++) begin
            fifo[p].delete();
            mdl[p].delete();
        end
        exp_q.delete();
        lg_m = 3;
        tick(1);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk_sys);
            if (exp_q.size() == 0 && fifo_total() == 0 && report_arb_state == 2'd0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending words expected 0", name, exp_q.size() + fifo_total());
        end
        tick(2);
    endtask

    initial begin
        int w0, pv0, he0, uf0, h0;
        reset_n = 1'b0;
        i_out_ready = 1'b0;
        timer = '0;
        iv_data = '0;
        iv_data_empty = 4'hF;
        tick(3);
        chk("rst_data", 32'(ov_data), 32'd0);
        chk("rst_wr", 32'(o_data_wr), 32'd0);
        chk("rst_rd", 32'(ov_data_rd), 32'd0);
        chk("rst_state", 32'(report_arb_state), 32'd0);
        chk("rst_pulses", 32'({o_pkt_valid_pulse, o_head_error_pulse, o_fifo_underflow_pulse}), 32'd0);
        reset_n = 1'b1;

        // Two 64-word packets on ports 0 and 2.
        do_reset();
        w0 = writes; pv0 = pv_seen; h0 = head_log.size();
        load_pkt(0, 64, 3);
        load_pkt(2, 64, 11);
        predict();
        i_out_ready = 1'b1;
        wait_drain(400, "two_port");
        chk("two_port_writes", 32'(writes - w0), 32'd128);
        chk("two_port_pkt_valid", 32'(pv_seen - pv0), 32'd2);
        chk("two_port_first", 32'(hl(h0)), 32'd0);
        chk("two_port_second", 32'(hl(h0 + 1)), 32'd2);

        // All ports loaded with two packets each.
        do_reset();
        h0 = head_log.size();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) load_pkt(p, 3 + p + k, 20 * k + p);
        predict();
        i_out_ready = 1'b1;
        wait_drain(300, "rr");
        for (int k = 0; k < 8; k++) chk($sformatf("rr_grant%0d", k), 32'(hl(h0 + k)), 32'(k % 4));

        // Headless packet on port 1 is discarded; next grant searches from port 2.
        do_reset();
        w0 = writes; he0 = he_seen; pv0 = pv_seen;
        push_word(1, 9'h055);
        for (int i = 0; i < 8; i++) push_word(1, 9'(8'h21 + i));
        push_word(1, 9'h1AA);
        predict();
        i_out_ready = 1'b1;
        wait_drain(100, "discard");
        chk("discard_head_err", 32'(he_seen - he0), 32'd1);
        chk("discard_writes", 32'(writes - w0), 32'd0);
        chk("discard_pkt_valid", 32'(pv_seen - pv0), 32'd0);
        chk("discard_state", 32'(report_arb_state), 32'd0);
        h0 = head_log.size();
        load_pkt(0, 3, 5);
        load_pkt(2, 3, 9);
        predict();
        wait_drain(100, "after_discard");
        chk("after_discard_first", 32'(hl(h0)), 32'd2);

        // Port 3 runs dry mid-packet for 300 cycles.
        do_reset();
        w0 = writes; uf0 = uf_seen; pv0 = pv_seen;
        for (int i = 0; i < 10; i++) begin
            logic [8:0] w;
            w = (i == 0) ? 9'h13C : 9'(8'h40 + i);
            fifo[3].push_back(w);
            exp_q.push_back('{w, 2'd3, (i == 0), 1'b0});
        end
`ifdef NETWORK_RX_ARB_WATCHDOG_EN
        exp_q.push_back('{9'h100, 2'd3, 1'b0, 1'b1});
`endif
        lg_m = 3;
        i_out_ready = 1'b1;
        tick(300);
`ifdef NETWORK_RX_ARB_WATCHDOG_EN
        chk("wd_writes_gap", 32'(writes - w0), 32'd11);
        chk("wd_underflow", 32'(uf_seen - uf0), 32'd1);
        chk("wd_timeout_delay", 32'(wr_cyc[wr_cyc.size() - 1] - wr_cyc[wr_cyc.size() - 2]), 32'd255);
`else
        chk("stall_writes_gap", 32'(writes - w0), 32'd10);
        chk("stall_state", 32'(report_arb_state), 32'd2);
`endif
        for (int i = 0; i < 4; i++) begin
            logic [8:0] w;
            w = (i == 3) ? 9'h1E7 : 9'(8'h70 + i);
            fifo[3].push_back(w);
`ifndef NETWORK_RX_ARB_WATCHDOG_EN
            exp_q.push_back('{w, 2'd3, 1'b0, 1'b0});
`endif
        end
        wait_drain(100, "refill");
`ifdef NETWORK_RX_ARB_WATCHDOG_EN
        chk("wd_total_writes", 32'(writes - w0), 32'd11);
        chk("wd_pkt_valid", 32'(pv_seen - pv0), 32'd0);
`else
        chk("stall_total_writes", 32'(writes - w0), 32'd14);
        chk("stall_underflow", 32'(uf_seen - uf0), 32'd0);
        chk("stall_pkt_valid", 32'(pv_seen - pv0), 32'd1);
`endif

        // Ready low blocks arbitration but not an in-flight packet.
        do_reset();
        w0 = writes; pv0 = pv_seen;
        for (int p = 0; p < 4; p++) load_pkt(p, 6, 30 + p);
        predict();
        tick(20);
        chk("noready_writes", 32'(writes - w0), 32'd0);
        chk("noready_fifo_total", 32'(fifo_total()), 32'd24);
        chk("noready_state", 32'(report_arb_state), 32'd0);
        i_out_ready = 1'b1;
        for (int k = 0; k < 50 && (writes - w0) < 3; k++) tick(1);
        i_out_ready = 1'b0;
        tick(20);
        chk("ready_drop_writes", 32'(writes - w0), 32'd6);
        chk("ready_drop_pkt_valid", 32'(pv_seen - pv0), 32'd1);
        chk("ready_drop_port1_left", 32'(fifo[1].size()), 32'd6);
        i_out_ready = 1'b1;
        wait_drain(200, "ready_resume");
        chk("ready_resume_writes", 32'(writes - w0), 32'd24);

        // Reset in the middle of a 40-word packet.
        do_reset();
        w0 = writes; he0 = he_seen;
        load_pkt(1, 40, 77);
        predict();
        i_out_ready = 1'b1;
        for (int k = 0; k < 100 && (writes - w0) < 20; k++) tick(1);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_data", 32'(ov_data), 32'd0);
        chk("midrst_wr", 32'(o_data_wr), 32'd0);
        chk("midrst_port_id", 32'(ov_port_id), 32'd0);
        chk("midrst_rd", 32'(ov_data_rd), 32'd0);
        chk("midrst_state", 32'(report_arb_state), 32'd0);
        @(negedge clk_sys);
        exp_q.delete();
        for (int p = 0; p < 4; p++) mdl[p] = fifo[p];
        lg_m = 3;
        tick(2);
        reset_n = 1'b1;
        predict();
        w0 = writes;
        wait_drain(100, "midrst");
        chk("midrst_head_err", 32'(he_seen - he0), 32'd1);
        chk("midrst_writes_after", 32'(writes - w0), 32'd0);

        chk("head_err_total", 32'(he_seen), 32'(he_exp));
        chk("bad_pops", 32'(bad_pops), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
